// File: rtl/tristate_line_pkg.sv
// Shared definitions for the tristate line receiver: FSM state encoding and line idle level.
package tristate_line_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        ACK_WAIT  = 3'd5,
        ACK       = 3'd6,
        WAIT_HIGH = 3'd7
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/line_sync.sv
// Two-flop synchronizer for the shared line; resets to the idle (high) level.
module line_sync
    import tristate_line_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= LINE_IDLE;
            q    <= LINE_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tristate_line_receiver.sv
// Serial frame receiver on a shared idle-high tristate line; acknowledges good frames by
// pulling the line low for one bit period. Define TRISTATE_LINE_RX_PARITY_EN for even parity.
module tristate_line_receiver
    import tristate_line_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BIT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               line,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy
);

    localparam int unsigned CW = $clog2(BIT_CYC);
    localparam int unsigned BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYC / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYC - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              ls;
    logic              expired;
    logic              par_ok;

    line_sync u_line_sync (
        .clk (clk),
        .rst (rst),
        .d   (line),
        .q   (ls)
    );

    assign expired = (cnt == '0);

`ifdef TRISTATE_LINE_RX_PARITY_EN
    logic par_bad;
    assign par_ok = ~par_bad;
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
`ifdef TRISTATE_LINE_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // IDLE is only ever entered with ls high, so a low ls is a falling edge
                    if (ls != LINE_IDLE) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (expired) begin
                        if (ls != LINE_IDLE) begin
                            cnt    <= FULL_LOAD;
                            bitcnt <= '0;
                            state  <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        shreg  <= (shreg >> 1) | (DATA_W'(ls) << (DATA_W - 1));
                        cnt    <= FULL_LOAD;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
`ifdef TRISTATE_LINE_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef TRISTATE_LINE_RX_PARITY_EN
                PARITY: begin
                    if (expired) begin
                        par_bad <= (ls != ^shreg);
                        cnt     <= FULL_LOAD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (expired) begin
                        if (ls == LINE_IDLE && par_ok) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            cnt      <= HALF_LOAD;
                            state    <= ACK_WAIT;
                        end else begin
                            // bad stop and/or bad parity collapse into one error pulse
                            rx_err <= 1'b1;
                            state  <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK_WAIT: begin
                    if (expired) begin
                        cnt   <= FULL_LOAD;
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    // ls is deliberately ignored here; our own drive would look like a start
                    if (expired) begin
                        state <= WAIT_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (ls == LINE_IDLE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive derives straight from the state flop so an async reset releases the line at once
    assign line = (state == ACK) ? 1'b0 : 1'bz;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tristate_line_receiver.sv
// Directed bench for tristate_line_receiver; models the remote driver plus the line pull-up.
module tb_tristate_line_receiver;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BIT_CYC = 16;
`ifdef TRISTATE_LINE_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              tb_low;
    wire               line;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              busy;

    assign line = tb_low ? 1'b0 : 1'bz;
    pullup (line);

    tristate_line_receiver #(
        .DATA_W  (DATA_W),
        .BIT_CYC (BIT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line     (line),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Monitor state, written only by the negedge monitor
    int   cyc       = 0;
    int   n_valid   = 0;
    int   n_err     = 0;
    int   n_both    = 0;
    int   busy_cnt  = 0;
    int   ack_runs  = 0;
    int   ack_start = 0;
    int   ack_len   = 0;
    int   valid_cyc = 0;
    logic ack_prev  = 1'b0;
    logic [DATA_W-1:0] data_log [0:7];

    wire dut_drv = (line == 1'b0) && !tb_low;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        ack_prev <= dut_drv;
        if (rx_valid) begin
            n_valid           <= n_valid + 1;
            valid_cyc         <= cyc;
            data_log[n_valid % 8] <= rx_data;
        end
        if (rx_err) n_err <= n_err + 1;
        if (rx_valid && rx_err) n_both <= n_both + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (dut_drv && !ack_prev) begin
            ack_runs  <= ack_runs + 1;
            ack_start <= cyc;
            ack_len   <= 1;
        end else if (dut_drv) begin
            ack_len <= ack_len + 1;
        end
    end

    int b_valid, b_err, b_runs, b_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_err   = n_err;
        b_runs  = ack_runs;
        b_busy  = busy_cnt;
    endtask

    task automatic send_bit(input logic b);
        tb_low = !b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    // Frame: start 0, data LSB first, optional even parity (flip to corrupt), stop bit
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop, input logic par_flip);
        @(posedge clk);
        #1;
        send_bit(1'b0);
        for (int i = 0; i < int'(DATA_W); i++) send_bit(d[i]);
        if (PAR_EN) send_bit((^d) ^ par_flip);
        send_bit(stop);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ack_done(input string tag, input int bound);
        int n = 0;
        while (!(ack_runs > b_runs && !ack_prev) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_done"}, {31'd0, (ack_runs > b_runs && !ack_prev)}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        tb_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_err", {31'd0, rx_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_line", {31'd0, line}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Good frame 0xA5 and ACK timing
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_idle("a5", 100);
        repeat (2) @(negedge clk);
        check("a5_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_err_cnt", 32'(n_err - b_err), 32'd0);
        check("a5_ack_runs", 32'(ack_runs - b_runs), 32'd1);
        check("a5_ack_len", 32'(ack_len), 32'd16);
        check("a5_ack_delay", 32'(ack_start - valid_cyc), 32'd8);

        // 4-cycle glitch in IDLE
        snap();
        @(posedge clk);
        #1 tb_low = 1'b1;
        repeat (4) @(posedge clk);
        #1 tb_low = 1'b0;
        wait_idle("glitch", 12);
        repeat (4) @(negedge clk);
        check("glitch_saw_busy", {31'd0, (busy_cnt > b_busy)}, 32'd1);
        check("glitch_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("glitch_err_cnt", 32'(n_err - b_err), 32'd0);
        check("glitch_ack_runs", 32'(ack_runs - b_runs), 32'd0);

        // 0x3C with bad stop bit, line stuck low 40 cycles
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("stop0_busy_hold", {31'd0, busy}, 32'd1);
        check("stop0_err_cnt", 32'(n_err - b_err), 32'd1);
        check("stop0_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("stop0_ack_runs", 32'(ack_runs - b_runs), 32'd0);
        check("stop0_rx_data", 32'(rx_data), 32'hA5);
        tb_low = 1'b0;
        repeat (3) @(negedge clk);
        check("stop0_busy_sync", {31'd0, busy}, 32'd1);
        wait_idle("stop0", 2);

        // Back-to-back frames 0x01 then 0xFF
        repeat (4) @(posedge clk);
        snap();
        send_frame(8'h01, 1'b1, 1'b0);
        wait_ack_done("b2b", 100);
        repeat (BIT_CYC) @(posedge clk);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_idle("b2b", 100);
        repeat (2) @(negedge clk);
        check("b2b_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        check("b2b_first", 32'(data_log[b_valid % 8]), 32'h01);
        check("b2b_second", 32'(data_log[(b_valid + 1) % 8]), 32'hFF);
        check("b2b_rx_data", 32'(rx_data), 32'hFF);
        check("b2b_ack_runs", 32'(ack_runs - b_runs), 32'd2);
        check("b2b_err_cnt", 32'(n_err - b_err), 32'd0);

        // Reset in the middle of ACK
        repeat (4) @(posedge clk);
        snap();
        send_frame(8'h81, 1'b1, 1'b0);
        begin
            int n = 0;
            while (!dut_drv && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("rstack_seen", {31'd0, dut_drv}, 32'd1);
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstack_line", {31'd0, line}, 32'd1);
        check("rstack_rx_data", 32'(rx_data), 32'h0);
        check("rstack_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rstack_rx_err", {31'd0, rx_err}, 32'd0);
        check("rstack_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        snap();
        send_frame(8'h55, 1'b1, 1'b0);
        wait_idle("post_rst", 100);
        repeat (2) @(negedge clk);
        check("post_rst_rx_data", 32'(rx_data), 32'h55);
        check("post_rst_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("post_rst_ack_len", 32'(ack_len), 32'd16);

`ifdef TRISTATE_LINE_RX_PARITY_EN
        // 0x07 with wrong parity, then correct parity
        repeat (4) @(posedge clk);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (30) @(posedge clk);
        wait_idle("par_bad", 100);
        check("par_bad_err_cnt", 32'(n_err - b_err), 32'd1);
        check("par_bad_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("par_bad_ack_runs", 32'(ack_runs - b_runs), 32'd0);
        check("par_bad_rx_data", 32'(rx_data), 32'h55);
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        wait_idle("par_ok", 100);
        repeat (2) @(negedge clk);
        check("par_ok_rx_data", 32'(rx_data), 32'h07);
        check("par_ok_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("par_ok_ack_runs", 32'(ack_runs - b_runs), 32'd1);
`endif

        check("valid_err_exclusive", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
